// File: rtl/core_pkg.sv
// Shared encodings for the core: scheduler phase, LSU lane state, fetcher state.
package core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_FETCH   = 3'b001,
        ST_DECODE  = 3'b010,
        ST_REQUEST = 3'b011,
        ST_WAIT    = 3'b100,
        ST_EXECUTE = 3'b101,
        ST_UPDATE  = 3'b110,
        ST_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_t;

    typedef enum logic [2:0] {
        FET_IDLE     = 3'b000,
        FET_FETCHING = 3'b001,
        FET_FETCHED  = 3'b010
    } fetcher_state_t;

    localparam logic [2:0] FETCHED = 3'b010;

endpackage

// File: rtl/core_scheduler_if.sv
// Scheduler-facing signal bundle: dispatcher/decoder/fetcher/LSU/PC inputs and broadcast outputs.
interface core_scheduler_if #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_WIDTH          = 8
);
    import core_pkg::*;

    logic                                start;
    logic [3:0]                          thread_count;
    logic                                decoded_mem_read_enable;
    logic                                decoded_mem_write_enable;
    logic                                decoded_ret;
    logic [2:0]                          fetcher_state;
    logic [2*THREADS_PER_BLOCK-1:0]      lsu_state;
    logic [PC_WIDTH*THREADS_PER_BLOCK-1:0] next_pc;
    core_state_t                         core_state;
    logic [PC_WIDTH-1:0]                 current_pc;
    logic                                done;
    logic                                diverged;

    modport master (
        output start, thread_count, decoded_mem_read_enable, decoded_mem_write_enable,
               decoded_ret, fetcher_state, lsu_state, next_pc,
        input  core_state, current_pc, done, diverged
    );

    modport slave (
        input  start, thread_count, decoded_mem_read_enable, decoded_mem_write_enable,
               decoded_ret, fetcher_state, lsu_state, next_pc,
        output core_state, current_pc, done, diverged
    );

endinterface

// File: rtl/thread_mask.sv
// Converts an active-lane count into a per-lane enable vector; counts above the lane total saturate.
module thread_mask #(
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic [3:0]                   thread_count,
    output logic [THREADS_PER_BLOCK-1:0] enable
);

    // Lane i is enabled when it lies below the requested count.
    for (genvar i = 0; i < THREADS_PER_BLOCK; i++) begin : g_lane
        assign enable[i] = (thread_count > 4'(i));
    end

endmodule

// File: rtl/core_scheduler.sv
// Per-core instruction sequencer: owns the shared PC, reconverges lane PCs, flags divergence.
module core_scheduler
    import core_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_WIDTH          = 8
) (
    input  logic          clk,
    input  logic          reset,
    core_scheduler_if.slave bus
);

    core_state_t                  state;
    logic [PC_WIDTH-1:0]          pc_q;
    logic                         done_q;
    logic                         diverged_q;
    logic [THREADS_PER_BLOCK-1:0] lane_en;
    logic                         any_busy;
    logic                         pc_mismatch;
    logic                         unused_mem_flags;

    // Memory-type flags are only meaningful to the LSUs; WAIT exit depends on LSU state alone.
    assign unused_mem_flags = bus.decoded_mem_read_enable ^ bus.decoded_mem_write_enable;

    thread_mask #(.THREADS_PER_BLOCK(THREADS_PER_BLOCK)) u_mask (
        .thread_count (bus.thread_count),
        .enable       (lane_en)
    );

    // Busy and divergence reductions over enabled lanes only.
    always_comb begin
        lsu_state_t lane_st;
        any_busy    = 1'b0;
        pc_mismatch = 1'b0;
        lane_st     = LSU_IDLE;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            lane_st = lsu_state_t'(bus.lsu_state[2*i +: 2]);
            if (lane_en[i] && (lane_st == LSU_REQUESTING || lane_st == LSU_WAITING))
                any_busy = 1'b1;
            if (lane_en[i] && (bus.next_pc[i*PC_WIDTH +: PC_WIDTH] != bus.next_pc[PC_WIDTH-1:0]))
                pc_mismatch = 1'b1;
        end
    end

    // Phase sequencer with registered PC, done and sticky divergence flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            pc_q       <= '0;
            done_q     <= 1'b0;
            diverged_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:    if (bus.start) state <= ST_FETCH;
                ST_FETCH:   if (bus.fetcher_state == FETCHED) state <= ST_DECODE;
                ST_DECODE:  state <= ST_REQUEST;
                ST_REQUEST: state <= ST_WAIT;
                ST_WAIT:    if (!any_busy) state <= ST_EXECUTE;
                ST_EXECUTE: state <= ST_UPDATE;
                ST_UPDATE: begin
                    if (pc_mismatch)
                        diverged_q <= 1'b1;
                    if (bus.decoded_ret) begin
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        pc_q  <= bus.next_pc[PC_WIDTH-1:0];
                        state <= ST_FETCH;
                    end
                end
                ST_DONE:    state <= ST_DONE;
            endcase
        end
    end

    assign bus.core_state = state;
    assign bus.current_pc = pc_q;
    assign bus.done       = done_q;
    assign bus.diverged   = diverged_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler: phase sequencing, WAIT masking, PC reconvergence, RET, reset.
module tb_core_scheduler;

    localparam logic [2:0] S_IDLE    = 3'b000;
    localparam logic [2:0] S_FETCH   = 3'b001;
    localparam logic [2:0] S_DECODE  = 3'b010;
    localparam logic [2:0] S_REQUEST = 3'b011;
    localparam logic [2:0] S_WAIT    = 3'b100;
    localparam logic [2:0] S_EXECUTE = 3'b101;
    localparam logic [2:0] S_UPDATE  = 3'b110;
    localparam logic [2:0] S_DONE    = 3'b111;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    core_scheduler_if #(.THREADS_PER_BLOCK(4), .PC_WIDTH(8)) bus ();

    core_scheduler #(.THREADS_PER_BLOCK(4), .PC_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Check current phase, then advance one cycle.
    task automatic st(input string tag, input logic [2:0] exp);
        chk(tag, 32'(bus.core_state), 32'(exp));
        @(negedge clk);
    endtask

    // One instruction with a single-cycle fetch and single-cycle wait.
    task automatic run_plain(input string tag);
        bus.fetcher_state = 3'b010;
        st({tag, "_fetch"}, S_FETCH);
        bus.fetcher_state = 3'b000;
        st({tag, "_decode"}, S_DECODE);
        st({tag, "_request"}, S_REQUEST);
        st({tag, "_wait"}, S_WAIT);
        st({tag, "_execute"}, S_EXECUTE);
        st({tag, "_update"}, S_UPDATE);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.thread_count = 4'd0;
        bus.decoded_mem_read_enable = 1'b0;
        bus.decoded_mem_write_enable = 1'b0;
        bus.decoded_ret = 1'b0;
        bus.fetcher_state = 3'b000;
        bus.lsu_state = 8'h00;
        bus.next_pc = 32'h0;
        repeat (2) @(negedge clk);

        chk("rst_state", 32'(bus.core_state), 32'(S_IDLE));
        chk("rst_pc", 32'(bus.current_pc), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_div", 32'(bus.diverged), 32'h0);

        // Basic instruction, fetch completes on the third FETCH cycle.
        reset = 1'b0;
        bus.start = 1'b1;
        bus.thread_count = 4'd4;
        bus.next_pc = 32'h01010101;
        st("s1_idle", S_IDLE);
        st("s1_fetch1", S_FETCH);
        st("s1_fetch2", S_FETCH);
        bus.fetcher_state = 3'b010;
        st("s1_fetch3", S_FETCH);
        bus.fetcher_state = 3'b000;
        st("s1_decode", S_DECODE);
        st("s1_request", S_REQUEST);
        st("s1_wait", S_WAIT);
        st("s1_execute", S_EXECUTE);
        chk("s1_pc_before", 32'(bus.current_pc), 32'h00);
        st("s1_update", S_UPDATE);
        chk("s1_next", 32'(bus.core_state), 32'(S_FETCH));
        chk("s1_pc", 32'(bus.current_pc), 32'h01);
        chk("s1_div", 32'(bus.diverged), 32'h0);

        // LDR: lane 2 finishes five cycles after the others.
        bus.decoded_mem_read_enable = 1'b1;
        bus.next_pc = 32'h02020202;
        bus.fetcher_state = 3'b010;
        st("s2_fetch", S_FETCH);
        bus.fetcher_state = 3'b000;
        st("s2_decode", S_DECODE);
        st("s2_request", S_REQUEST);
        for (int k = 1; k <= 7; k++) begin
            if (k == 1)      bus.lsu_state = 8'hAA;
            else if (k < 7)  bus.lsu_state = 8'hEF;
            else             bus.lsu_state = 8'hFF;
            st($sformatf("s2_wait%0d", k), S_WAIT);
        end
        bus.lsu_state = 8'h00;
        bus.decoded_mem_read_enable = 1'b0;
        st("s2_execute", S_EXECUTE);
        st("s2_update", S_UPDATE);
        chk("s2_next", 32'(bus.core_state), 32'(S_FETCH));
        chk("s2_pc", 32'(bus.current_pc), 32'h02);

        // Two lanes; disabled lane 3 busy and disagreeing is ignored.
        bus.thread_count = 4'd2;
        bus.lsu_state = 8'h40;
        bus.next_pc = 32'h55101010;
        run_plain("s3");
        chk("s3_next", 32'(bus.core_state), 32'(S_FETCH));
        chk("s3_pc", 32'(bus.current_pc), 32'h10);
        chk("s3_div", 32'(bus.diverged), 32'h0);

        // Four lanes, lane 2 diverges; flag must stick.
        bus.thread_count = 4'd4;
        bus.lsu_state = 8'h00;
        bus.next_pc = 32'h10221010;
        run_plain("s4a");
        chk("s4a_pc", 32'(bus.current_pc), 32'h10);
        chk("s4a_div", 32'(bus.diverged), 32'h1);
        bus.next_pc = 32'h07070707;
        run_plain("s4b");
        chk("s4b_pc", 32'(bus.current_pc), 32'h07);
        chk("s4b_div", 32'(bus.diverged), 32'h1);

        // RET: DONE is terminal, PC held, start ignored.
        bus.decoded_ret = 1'b1;
        bus.next_pc = 32'h33333333;
        run_plain("s5");
        chk("s5_state", 32'(bus.core_state), 32'(S_DONE));
        chk("s5_done", 32'(bus.done), 32'h1);
        chk("s5_pc", 32'(bus.current_pc), 32'h07);
        bus.start = 1'b0;
        @(negedge clk);
        chk("s5_hold0", 32'(bus.core_state), 32'(S_DONE));
        bus.start = 1'b1;
        @(negedge clk);
        chk("s5_hold1", 32'(bus.core_state), 32'(S_DONE));
        chk("s5_done_hold", 32'(bus.done), 32'h1);
        chk("s5_pc_hold", 32'(bus.current_pc), 32'h07);
        bus.decoded_ret = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("s5_rst_state", 32'(bus.core_state), 32'(S_IDLE));
        chk("s5_rst_done", 32'(bus.done), 32'h0);
        chk("s5_rst_pc", 32'(bus.current_pc), 32'h00);
        chk("s5_rst_div", 32'(bus.diverged), 32'h0);

        // Reset mid-WAIT with busy lanes after a divergent instruction.
        reset = 1'b0;
        bus.next_pc = 32'h44454444;
        st("s6_idle", S_IDLE);
        run_plain("s6a");
        chk("s6a_pc", 32'(bus.current_pc), 32'h44);
        chk("s6a_div", 32'(bus.diverged), 32'h1);
        bus.decoded_mem_read_enable = 1'b1;
        bus.fetcher_state = 3'b010;
        st("s6_fetch", S_FETCH);
        bus.fetcher_state = 3'b000;
        st("s6_decode", S_DECODE);
        bus.lsu_state = 8'h55;
        st("s6_request", S_REQUEST);
        st("s6_wait1", S_WAIT);
        st("s6_wait2", S_WAIT);
        chk("s6_wait3", 32'(bus.core_state), 32'(S_WAIT));
        reset = 1'b1;
        @(negedge clk);
        chk("s6_rst_state", 32'(bus.core_state), 32'(S_IDLE));
        chk("s6_rst_pc", 32'(bus.current_pc), 32'h00);
        chk("s6_rst_done", 32'(bus.done), 32'h0);
        chk("s6_rst_div", 32'(bus.diverged), 32'h0);

        // thread_count=0: lane 0 still supplies PC, busy lanes and divergence ignored.
        reset = 1'b0;
        bus.decoded_mem_read_enable = 1'b0;
        bus.thread_count = 4'd0;
        bus.lsu_state = 8'hAA;
        bus.next_pc = 32'h01020304;
        st("s7_idle", S_IDLE);
        run_plain("s7");
        chk("s7_next", 32'(bus.core_state), 32'(S_FETCH));
        chk("s7_pc", 32'(bus.current_pc), 32'h04);
        chk("s7_div", 32'(bus.diverged), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_scheduler.md
Name: core_scheduler

Overview:
- Per-core control FSM. Sequences every instruction through FETCH→DECODE→REQUEST→WAIT→EXECUTE→UPDATE.
- Broadcasts `core_state` to the fetcher, decoder, LSUs, ALUs and the per-thread PC units.
- Owns the single shared `current_pc` and reconverges the per-thread `next_pc` values that the PC units produce in EXECUTE.
- Signals block completion on RET and flags thread divergence.

Parameters:
- THREADS_PER_BLOCK, 4, number of thread lanes (PC/LSU instances) in the core; range 1..8.
- PC_WIDTH, 8, program-counter width.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- start  input  1  level; dispatcher asserts to launch the block
- thread_count  input  4  active lanes in this block; lanes 0..thread_count-1 enabled; values >THREADS_PER_BLOCK saturate
- decoded_mem_read_enable  input  1  current instruction is LDR
- decoded_mem_write_enable  input  1  current instruction is STR
- decoded_ret  input  1  current instruction is RET
- fetcher_state  input  3  fetcher FSM state; FETCHED = 3'b010
- lsu_state  input  2*THREADS_PER_BLOCK  packed per-lane LSU state: IDLE=0, REQUESTING=1, WAITING=2, DONE=3
- next_pc  input  PC_WIDTH*THREADS_PER_BLOCK  packed per-lane next PC from PC units
- core_state  output  3  current phase, broadcast
- current_pc  output  PC_WIDTH  shared PC of the block
- done  output  1  block finished; held until reset
- diverged  output  1  sticky: enabled lanes disagreed on next_pc at least once

Behaviour:
- State encodings (shared package): IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111.
- Reset: core_state=IDLE, current_pc=0, done=0, diverged=0. Reset takes effect in any state, including mid-WAIT; LSU handshakes in flight are abandoned.
- IDLE: if start=1, go to FETCH next cycle. current_pc is not cleared on start; the dispatcher resets the core between blocks.
- FETCH: stay until fetcher_state==FETCHED, then go to DECODE.
- DECODE: exactly 1 cycle, then REQUEST.
- REQUEST: exactly 1 cycle, then WAIT. LSUs sample core_state here.
- WAIT:
  - Compute any_busy over enabled lanes only, where busy = lsu_state ∈ {REQUESTING, WAITING}.
  - Go to EXECUTE on the first cycle with any_busy==0. Minimum 1 cycle in WAIT.
  - For non-memory instructions, all LSUs remain IDLE, so WAIT lasts 1 cycle.
  - Disabled lanes are ignored even if busy.
- EXECUTE: exactly 1 cycle, then UPDATE. PC units register next_pc at the end of this cycle.
- UPDATE (1 cycle):
  - If decoded_ret: go to DONE, set done=1, leave current_pc unchanged.
  - Else: current_pc ← next_pc of lane 0, then go to FETCH.
  - In the same cycle, compare next_pc of every enabled lane against lane 0. Any mismatch sets diverged=1 (sticky until reset). Lane 0's PC is taken regardless.
- DONE: terminal until reset. start is ignored.
- thread_count==0: lane 0 is still treated as enabled for PC selection. The LSU wait ignores all lanes, and the divergence check is disabled.
- PC arithmetic is owned by the PC units. current_pc wraps naturally at 2^PC_WIDTH; no overflow flag.
- Every instruction has a fixed 4-cycle overhead (DECODE, REQUEST, EXECUTE, UPDATE) plus the fetch and wait durations.

Decomposition:
- Package core_pkg:
  - core_state_t enum and its encodings (shared with the PC unit, fetcher, decoder, LSU).
  - lsu_state_t and fetcher_state_t encodings.
  - Constant FETCHED = 3'b010.
- Sub-module thread_mask (combinational): converts thread_count to an enable vector with saturation. Reused by the PC/LSU enable wiring.
- The divergence comparator stays inline.

Test Plan:
- Reset then start=1, thread_count=4, fetcher asserts FETCHED 2 cycles after FETCH, non-memory instruction, all next_pc=8'h01 → states IDLE,FETCH×3,DECODE,REQUEST,WAIT,EXECUTE,UPDATE,FETCH; current_pc=1 after UPDATE; diverged=0.
- LDR with lanes 0..3 in WAITING; lane 2 goes DONE 5 cycles after the others → remain in WAIT until lane 2 leaves WAITING, then EXECUTE.
- thread_count=2, lane 3 stuck in REQUESTING and next_pc lane 3=8'h55 while lanes 0/1=8'h10 → WAIT exits normally; current_pc=8'h10; diverged=0.
- thread_count=4, lanes next_pc {10,10,22,10} → current_pc=8'h10, diverged=1, and it stays 1 across later matching instructions.
- decoded_ret during UPDATE with current_pc=8'h07 → DONE, done=1, current_pc stays 8'h07; toggling start has no effect; reset returns to IDLE with done=0.
- Reset asserted while in WAIT with lanes busy → next cycle core_state=IDLE, current_pc=0, done=0, diverged=0.
